// File: rtl/sw_bcd_dncntr_if.sv
// Control/data bundle for the two-digit BCD down-counter.
//   en     : count tick, one decrement per cycle while running
//   start  : idle -> run
//   stop   : run -> idle (pause, value held)
//   load   : preset the counter from ldval (clamped), forces idle
//   ldval  : {left digit, right digit} preset value
//   bcd    : current count {left, right}
//   borrow : one-cycle pulse on a decrement from 00
//   zero   : bcd == 00
//   busy   : counter is running
//   done   : one-shot countdown expired
interface sw_bcd_dncntr_if;
    logic       en;
    logic       start;
    logic       stop;
    logic       load;
    logic [7:0] ldval;
    logic [7:0] bcd;
    logic       borrow;
    logic       zero;
    logic       busy;
    logic       done;

    modport master (
        output en, start, stop, load, ldval,
        input  bcd, borrow, zero, busy, done
    );

    modport slave (
        input  en, start, stop, load, ldval,
        output bcd, borrow, zero, busy, done
    );
endinterface

// File: rtl/sw_bcd_dncntr.sv
// Two-digit BCD down-counter for countdown timers. Pairs cascade through
// borrow -> en of the next pair to build mm:ss countdowns.
//   clk1k : 1 kHz clock, all flops on posedge
//   rstn  : synchronous active-low reset
//   bus   : slave side of sw_bcd_dncntr_if (controls in, count/status out)
// Parameters:
//   MAXL/MAXR : value reloaded on wrap, and the upper bound for a load
//   WRAP      : 1 = 00 wraps to {MAXL,MAXR}; 0 = stop at 00 and enter DONE
// All outputs are registered and change together with the count.
module sw_bcd_dncntr #(
    parameter logic [3:0] MAXL = 4'h5,
    parameter logic [3:0] MAXR = 4'h9,
    parameter bit         WRAP = 1'b1
) (
    input  logic           clk1k,
    input  logic           rstn,
    sw_bcd_dncntr_if.slave bus
);

    localparam logic [7:0] MAXV = {MAXL, MAXR};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Saturate a preset so the counter never holds a non-BCD digit or a
    // value above the wrap value.
    function automatic logic [7:0] clamp(input logic [7:0] v);
        logic [3:0] l;
        logic [3:0] r;
        l = v[7:4];
        r = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        if (l > MAXL || (l == MAXL && r > MAXR))
            return MAXV;
        return {l, r};
    endfunction

    // Non-zero decrement; the 00 case is handled by the caller.
    function automatic logic [7:0] dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        return {v[7:4] - 4'd1, 4'd9};
    endfunction

    always_ff @(posedge clk1k) begin
        if (!rstn) begin
            state      <= IDLE;
            bus.bcd    <= 8'h00;
            bus.borrow <= 1'b0;
            bus.zero   <= 1'b1;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.borrow <= 1'b0;
            if (bus.load) begin
                // load wins over everything and leaves any state, DONE included
                state    <= IDLE;
                bus.bcd  <= clamp(bus.ldval);
                bus.zero <= (clamp(bus.ldval) == 8'h00);
                bus.busy <= 1'b0;
                bus.done <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.stop) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else if (bus.en) begin
                            if (bus.bcd == 8'h00) begin
                                bus.borrow <= 1'b1;
                                if (WRAP) begin
                                    bus.bcd  <= MAXV;
                                    bus.zero <= (MAXV == 8'h00);
                                end else begin
                                    // one-shot: hold 00, wait for a load
                                    state    <= DONE;
                                    bus.busy <= 1'b0;
                                    bus.done <= 1'b1;
                                end
                            end else begin
                                bus.bcd  <= dec(bus.bcd);
                                bus.zero <= (dec(bus.bcd) == 8'h00);
                            end
                        end
                    end
                    DONE: begin
                        // hold until load
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sw_bcd_dncntr.sv
// Directed bench: one wrapping and one one-shot counter driven by the same
// stimulus, expected values hand-computed.
module tb_sw_bcd_dncntr;

    logic clk1k = 1'b0;
    logic rstn;

    always #5 clk1k = ~clk1k;

    sw_bcd_dncntr_if ia ();
    sw_bcd_dncntr_if ib ();

    assign ib.en    = ia.en;
    assign ib.start = ia.start;
    assign ib.stop  = ia.stop;
    assign ib.load  = ia.load;
    assign ib.ldval = ia.ldval;

    sw_bcd_dncntr #(.MAXL(4'h5), .MAXR(4'h9), .WRAP(1'b1)) u_wrap (
        .clk1k (clk1k),
        .rstn  (rstn),
        .bus   (ia.slave)
    );

    sw_bcd_dncntr #(.MAXL(4'h5), .MAXR(4'h9), .WRAP(1'b0)) u_once (
        .clk1k (clk1k),
        .rstn  (rstn),
        .bus   (ib.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock, sample 1 time unit after the edge
    task automatic step();
        @(posedge clk1k);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        ia.load  = 1'b1;
        ia.ldval = v;
        step();
        ia.load  = 1'b0;
    endtask

    task automatic do_start();
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
    endtask

    initial begin
        ia.en = 1'b0; ia.start = 1'b0; ia.stop = 1'b0; ia.load = 1'b0; ia.ldval = 8'h00;

        // reset dominates load/en in the same cycle
        rstn = 1'b0; ia.en = 1'b1; ia.load = 1'b1; ia.ldval = 8'h42;
        step();
        chk("rst_bcd",    ia.bcd,    8'h00);
        chk("rst_zero",   ia.zero,   1'b1);
        chk("rst_busy",   ia.busy,   1'b0);
        chk("rst_borrow", ia.borrow, 1'b0);
        chk("rst_done",   ib.done,   1'b0);
        rstn = 1'b1; ia.en = 1'b0; ia.load = 1'b0;

        // plain countdown across the digit boundary
        do_load(8'h10);
        chk("ld10_bcd",  ia.bcd,  8'h10);
        chk("ld10_busy", ia.busy, 1'b0);
        ia.en = 1'b1;
        do_start();                          // en ignored in the start cycle
        chk("start_bcd",  ia.bcd,  8'h10);
        chk("start_busy", ia.busy, 1'b1);
        step();
        chk("dec_09", ia.bcd, 8'h09);
        step();
        chk("dec_08",     ia.bcd,    8'h08);
        chk("dec_borrow", ia.borrow, 1'b0);
        chk("dec_busy",   ia.busy,   1'b1);
        ia.en = 1'b0;
        step();
        chk("hold_en0", ia.bcd, 8'h08);

        // underflow: wrap vs one-shot
        do_load(8'h01);
        do_start();
        ia.en = 1'b1;
        step();
        chk("uf_00_a",    ia.bcd,    8'h00);
        chk("uf_zero_a",  ia.zero,   1'b1);
        chk("uf_00_b",    ib.bcd,    8'h00);
        chk("uf_nobor_b", ib.borrow, 1'b0);
        step();
        chk("wrap_59",     ia.bcd,    8'h59);
        chk("wrap_borrow", ia.borrow, 1'b1);
        chk("wrap_zero",   ia.zero,   1'b0);
        chk("wrap_busy",   ia.busy,   1'b1);
        chk("once_bcd",    ib.bcd,    8'h00);
        chk("once_borrow", ib.borrow, 1'b1);
        chk("once_done",   ib.done,   1'b1);
        chk("once_busy",   ib.busy,   1'b0);
        step();
        chk("wrap_58",      ia.bcd,    8'h58);
        chk("wrap_bor_off", ia.borrow, 1'b0);
        chk("once_hold",    ib.bcd,    8'h00);
        chk("once_bor_off", ib.borrow, 1'b0);
        chk("once_done2",   ib.done,   1'b1);
        ia.en = 1'b0;
        do_start();                          // ignored in DONE
        chk("done_start_done", ib.done, 1'b1);
        chk("done_start_busy", ib.busy, 1'b0);

        // load clamp, also leaves DONE
        do_load(8'h7A);
        chk("clamp_7A",  ia.bcd,  8'h59);
        chk("load_exit", ib.done, 1'b0);
        do_load(8'h3F);
        chk("clamp_3F", ia.bcd, 8'h39);
        do_load(8'h5C);
        chk("clamp_5C", ia.bcd, 8'h59);
        do_load(8'h00);
        chk("ld00_zero", ia.zero, 1'b1);

        // load + stop + en while running
        do_load(8'h25);
        do_start();
        ia.load = 1'b1; ia.stop = 1'b1; ia.en = 1'b1; ia.ldval = 8'h42;
        step();
        chk("lse_bcd",    ia.bcd,    8'h42);
        chk("lse_busy",   ia.busy,   1'b0);
        chk("lse_borrow", ia.borrow, 1'b0);
        ia.load = 1'b0; ia.stop = 1'b0; ia.en = 1'b0;

        // stop + en while running: no decrement
        do_load(8'h25);
        do_start();
        ia.stop = 1'b1; ia.en = 1'b1;
        step();
        chk("se_bcd",  ia.bcd,  8'h25);
        chk("se_busy", ia.busy, 1'b0);
        ia.stop = 1'b0;
        step();                              // idle: en has no effect
        chk("idle_hold", ia.bcd, 8'h25);

        // reset mid-run
        do_start();
        step();
        chk("run_24", ia.bcd, 8'h24);
        rstn = 1'b0;
        step();
        chk("mid_rst_bcd",  ia.bcd,  8'h00);
        chk("mid_rst_busy", ia.busy, 1'b0);
        rstn = 1'b1; ia.en = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
